// File: rtl/banked_reg_bank.sv
// rtl/banked_reg_bank.sv - mode-banked register bank with user/kernel FSM and registered read ports
//
// Purpose: REG_COUNT general registers, with SP and LR banked per privilege
// mode. A user/kernel FSM handles traps and returns, and an illegal transition
// raises a one-cycle fault. Every read port is registered, and each one shows the
// value that results from this edge's update (write-through).
//
// Ports:
//   fast_clock, reset      clock; synchronous active-high reset
//   enable, control        commit strobe and operation select
//   register_source_A/B    read port indices for read_data_A/B
//   register_Dest          write index, also read back on memory_output
//   ALU_result, data_from_memory, new_SP, new_PC, special_register  write data
//   read_data_A/B, current_PC, current_SP, memory_output            registered reads
//   privileged             1 = kernel mode
//   fault                  one-cycle pulse on trap-in-kernel or return-in-user
module banked_reg_bank #(
  parameter int WORD_SIZE        = 32,
  parameter int REG_COUNT        = 16,
  parameter int ADDR_BITS        = 4,
  parameter int PC_REGISTER      = 15,
  parameter int SP_REGISTER      = 14,
  parameter int LR_REGISTER      = 13,
  parameter int SYSCALL_REGISTER = 7,
  parameter int USER_STACK       = 8191,
  parameter int KERNEL_STACK     = 6143,
  parameter int OS_START         = 2048
) (
  input  logic                 fast_clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           control,
  input  logic [ADDR_BITS-1:0] register_source_A,
  input  logic [ADDR_BITS-1:0] register_source_B,
  input  logic [ADDR_BITS-1:0] register_Dest,
  input  logic [WORD_SIZE-1:0] ALU_result,
  input  logic [WORD_SIZE-1:0] data_from_memory,
  input  logic [WORD_SIZE-1:0] new_SP,
  input  logic [WORD_SIZE-1:0] new_PC,
  input  logic [3:0]           special_register,
  output logic [WORD_SIZE-1:0] read_data_A,
  output logic [WORD_SIZE-1:0] read_data_B,
  output logic [WORD_SIZE-1:0] current_PC,
  output logic [WORD_SIZE-1:0] current_SP,
  output logic [WORD_SIZE-1:0] memory_output,
  output logic                 privileged,
  output logic                 fault
);

  typedef enum logic {USER = 1'b0, KERNEL = 1'b1} mode_t;

  localparam logic [ADDR_BITS-1:0] PC_IDX  = ADDR_BITS'(PC_REGISTER);
  localparam logic [ADDR_BITS-1:0] SP_IDX  = ADDR_BITS'(SP_REGISTER);
  localparam logic [ADDR_BITS-1:0] LR_IDX  = ADDR_BITS'(LR_REGISTER);
  localparam logic [ADDR_BITS-1:0] SYS_IDX = ADDR_BITS'(SYSCALL_REGISTER);

  mode_t                state, next_state;
  logic [WORD_SIZE-1:0] general_regs [REG_COUNT];
  logic [WORD_SIZE-1:0] pc, user_sp, kernel_sp, user_lr, kernel_lr;
  logic [WORD_SIZE-1:0] next_pc, next_user_sp, next_kernel_sp, next_user_lr, next_kernel_lr;
  logic                 gen_we;
  logic [ADDR_BITS-1:0] gen_idx;
  logic [WORD_SIZE-1:0] gen_data;
  logic                 next_fault;
  logic [WORD_SIZE-1:0] dest_data;
  logic                 dest_writable;

  always_comb begin
    unique case (control)
      3'd2:    dest_data = data_from_memory;
      3'd5:    dest_data = {{(WORD_SIZE-4){1'b0}}, special_register};
      default: dest_data = ALU_result;
    endcase
  end

  // PC and SP can't be targeted by a data write; they only move via new_PC/new_SP.
  assign dest_writable = (register_Dest != PC_IDX) && (register_Dest != SP_IDX);

  always_comb begin
    next_state     = state;
    next_pc        = pc;
    next_user_sp   = user_sp;
    next_kernel_sp = kernel_sp;
    next_user_lr   = user_lr;
    next_kernel_lr = kernel_lr;
    gen_we         = 1'b0;
    gen_idx        = register_Dest;
    gen_data       = dest_data;
    next_fault     = 1'b0;
    if (enable) begin
      unique case (control)
        3'd1, 3'd2, 3'd5: begin
          if (dest_writable) begin
            if (register_Dest == LR_IDX) begin
              if (state == KERNEL) next_kernel_lr = dest_data;
              else                 next_user_lr   = dest_data;
            end else begin
              gen_we = 1'b1;
            end
          end
          next_pc = new_PC;
          if (control == 3'd2) begin
            if (state == KERNEL) next_kernel_sp = new_SP;
            else                 next_user_sp   = new_SP;
          end
        end
        3'd3: begin
          if (state == USER) begin
            next_kernel_lr = pc;
            gen_we         = 1'b1;
            gen_idx        = SYS_IDX;
            gen_data       = ALU_result;
            next_pc        = WORD_SIZE'(OS_START);
            next_state     = KERNEL;
          end else begin
            next_fault = 1'b1;
          end
        end
        3'd4: begin
          if (state == KERNEL) begin
            next_pc    = kernel_lr;
            next_state = USER;
          end else begin
            next_fault = 1'b1;
          end
        end
        default: begin
          if (state == KERNEL) next_kernel_sp = new_SP;
          else                 next_user_sp   = new_SP;
          next_pc = new_PC;
        end
      endcase
    end
  end

  // Resolves an index against the post-update state so reads see same-edge writes.
  function automatic logic [WORD_SIZE-1:0] read_next(input logic [ADDR_BITS-1:0] idx);
    if (idx == PC_IDX)
      return next_pc;
    else if (idx == SP_IDX)
      return (next_state == KERNEL) ? next_kernel_sp : next_user_sp;
    else if (idx == LR_IDX)
      return (next_state == KERNEL) ? next_kernel_lr : next_user_lr;
    else if (gen_we && (idx == gen_idx))
      return gen_data;
    else
      return general_regs[idx];
  endfunction

  always_ff @(posedge fast_clock) begin
    if (reset) state <= USER;
    else       state <= next_state;
  end

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) general_regs[i] <= '0;
      pc            <= '0;
      user_sp       <= WORD_SIZE'(USER_STACK);
      kernel_sp     <= WORD_SIZE'(KERNEL_STACK);
      user_lr       <= '0;
      kernel_lr     <= '0;
      read_data_A   <= '0;
      read_data_B   <= '0;
      current_PC    <= '0;
      current_SP    <= '0;
      memory_output <= '0;
      privileged    <= 1'b0;
      fault         <= 1'b0;
    end else begin
      if (gen_we) general_regs[gen_idx] <= gen_data;
      pc            <= next_pc;
      user_sp       <= next_user_sp;
      kernel_sp     <= next_kernel_sp;
      user_lr       <= next_user_lr;
      kernel_lr     <= next_kernel_lr;
      read_data_A   <= read_next(register_source_A);
      read_data_B   <= read_next(register_source_B);
      current_PC    <= next_pc;
      current_SP    <= (next_state == KERNEL) ? next_kernel_sp : next_user_sp;
      memory_output <= read_next(register_Dest);
      privileged    <= (next_state == KERNEL);
      fault         <= next_fault;
    end
  end

endmodule

// File: tb/tb_banked_reg_bank.sv
// tb/tb_banked_reg_bank.sv - directed self-checking bench for banked_reg_bank
module tb_banked_reg_bank;

  logic        fast_clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  control;
  logic [3:0]  register_source_A, register_source_B, register_Dest;
  logic [31:0] ALU_result, data_from_memory, new_SP, new_PC;
  logic [3:0]  special_register;
  logic [31:0] read_data_A, read_data_B, current_PC, current_SP, memory_output;
  logic        privileged, fault;

  int checks   = 0;
  int failures = 0;

  banked_reg_bank dut (
    .fast_clock(fast_clock), .reset(reset), .enable(enable), .control(control),
    .register_source_A(register_source_A), .register_source_B(register_source_B),
    .register_Dest(register_Dest), .ALU_result(ALU_result),
    .data_from_memory(data_from_memory), .new_SP(new_SP), .new_PC(new_PC),
    .special_register(special_register), .read_data_A(read_data_A),
    .read_data_B(read_data_B), .current_PC(current_PC), .current_SP(current_SP),
    .memory_output(memory_output), .privileged(privileged), .fault(fault)
  );

  always #5 fast_clock = ~fast_clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask

  task automatic op(input logic [2:0] c, input logic [3:0] d, input logic [3:0] a,
                    input logic [3:0] b, input logic [31:0] alu, input logic [31:0] pcv,
                    input logic [31:0] spv);
    enable = 1'b1; control = c; register_Dest = d;
    register_source_A = a; register_source_B = b;
    ALU_result = alu; new_PC = pcv; new_SP = spv;
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; control = 3'd0;
    register_source_A = 4'd0; register_source_B = 4'd0; register_Dest = 4'd0;
    ALU_result = '0; data_from_memory = '0; new_SP = '0; new_PC = '0; special_register = '0;
    tick(); tick();
    check("rst_pc", current_PC, 32'd0);
    check("rst_sp", current_SP, 32'd0);
    check("rst_rda", read_data_A, 32'd0);
    check("rst_priv", {31'd0, privileged}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);

    reset = 1'b0;
    tick();
    check("rel_pc", current_PC, 32'd0);
    check("rel_sp", current_SP, 32'd8191);
    check("rel_priv", {31'd0, privileged}, 32'd0);

    op(3'd1, 4'd3, 4'd3, 4'd0, 32'hDEADBEEF, 32'd4, 32'd8191);
    check("alu_wr_rda", read_data_A, 32'hDEADBEEF);
    check("alu_wr_pc", current_PC, 32'd4);
    check("alu_wr_memout", memory_output, 32'hDEADBEEF);

    op(3'd1, 4'd15, 4'd15, 4'd3, 32'h12345678, 32'd8, 32'd8191);
    check("pc_dest_rda", read_data_A, 32'd8);
    check("pc_dest_rdb", read_data_B, 32'hDEADBEEF);
    check("pc_dest_pc", current_PC, 32'd8);

    op(3'd1, 4'd14, 4'd14, 4'd0, 32'h55, 32'h40, 32'h77);
    check("sp_dest_rda", read_data_A, 32'd8191);
    check("sp_dest_sp", current_SP, 32'd8191);

    data_from_memory = 32'h0000A5A5;
    op(3'd2, 4'd5, 4'd5, 4'd0, 32'h0, 32'h40, 32'd8191);
    check("mem_wr_rda", read_data_A, 32'h0000A5A5);

    special_register = 4'hB;
    op(3'd5, 4'd2, 4'd2, 4'd5, 32'h0, 32'h40, 32'd8191);
    check("spec_wr_rda", read_data_A, 32'h0000000B);
    check("spec_keep_rdb", read_data_B, 32'h0000A5A5);

    op(3'd1, 4'd13, 4'd13, 4'd0, 32'h111, 32'h40, 32'd8191);
    check("user_lr_wr", read_data_A, 32'h111);
    check("pre_trap_pc", current_PC, 32'h40);

    op(3'd3, 4'd0, 4'd7, 4'd13, 32'd9, 32'h0, 32'h0);
    check("trap_priv", {31'd0, privileged}, 32'd1);
    check("trap_pc", current_PC, 32'd2048);
    check("trap_sp", current_SP, 32'd6143);
    check("trap_r7", read_data_A, 32'd9);
    check("trap_klr", read_data_B, 32'h40);
    check("trap_fault", {31'd0, fault}, 32'd0);

    op(3'd0, 4'd0, 4'd14, 4'd0, 32'h0, 32'h900, 32'd6000);
    check("k_adv_sp", current_SP, 32'd6000);
    check("k_adv_pc", current_PC, 32'h900);

    op(3'd4, 4'd0, 4'd14, 4'd13, 32'h0, 32'h0, 32'h0);
    check("ret_pc", current_PC, 32'h40);
    check("ret_sp", current_SP, 32'd8191);
    check("ret_priv", {31'd0, privileged}, 32'd0);
    check("ret_ulr", read_data_B, 32'h111);

    op(3'd3, 4'd0, 4'd7, 4'd13, 32'd1, 32'h0, 32'h0);
    check("trap2_sp", current_SP, 32'd6000);
    check("trap2_pc", current_PC, 32'd2048);
    check("trap2_klr", read_data_B, 32'h40);

    op(3'd3, 4'd0, 4'd7, 4'd13, 32'd5, 32'h0, 32'h0);
    check("ktrap_fault", {31'd0, fault}, 32'd1);
    check("ktrap_pc", current_PC, 32'd2048);
    check("ktrap_sp", current_SP, 32'd6000);
    check("ktrap_priv", {31'd0, privileged}, 32'd1);
    check("ktrap_r7", read_data_A, 32'd1);
    enable = 1'b0;
    tick();
    check("ktrap_fault_clr", {31'd0, fault}, 32'd0);

    op(3'd4, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
    check("ret2_pc", current_PC, 32'h40);
    op(3'd4, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0, 32'h0);
    check("uret_fault", {31'd0, fault}, 32'd1);
    check("uret_pc", current_PC, 32'h40);
    check("uret_sp", current_SP, 32'd8191);
    check("uret_priv", {31'd0, privileged}, 32'd0);
    enable = 1'b0;
    tick();
    check("uret_fault_clr", {31'd0, fault}, 32'd0);

    op(3'd3, 4'd0, 4'd0, 4'd0, 32'd2, 32'h0, 32'h0);
    check("trap3_priv", {31'd0, privileged}, 32'd1);
    reset = 1'b1;
    op(3'd1, 4'd3, 4'd3, 4'd0, 32'hFFFF, 32'h44, 32'h0);
    check("krst_priv", {31'd0, privileged}, 32'd0);
    check("krst_pc", current_PC, 32'd0);
    reset = 1'b0; enable = 1'b0; register_source_A = 4'd3;
    tick();
    check("krst_r3", read_data_A, 32'd0);
    check("krst_pc2", current_PC, 32'd0);
    check("krst_sp", current_SP, 32'd8191);
    check("krst_priv2", {31'd0, privileged}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
